turn_switch_conditioner: RTL and testbench
==========================================

Name: turn_switch_conditioner

Overview:
Upstream front end for the turn-signal controller. Takes raw, bouncy, active-low left/right pushbuttons. Synchronizes and debounces them, then issues clean single-cycle left/right request pulses that the turn-signal controller latches as its L/R selection. Also exports the debounced levels and a conflict flag for status LEDs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronized input must differ from the stable state before the stable state changes; legal range 2..65535
CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter; derived, not overridden

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
left_sw_n  input  1  raw left button, active-low (0 = pressed), asynchronous to clk
right_sw_n  input  1  raw right button, active-low, asynchronous to clk
left  output  1  one-cycle pulse on a qualified left press; drives controller left
right  output  1  one-cycle pulse on a qualified right press; drives controller right
left_level  output  1  debounced left state, 1 = pressed
right_level  output  1  debounced right state, 1 = pressed
conflict  output  1  one-cycle pulse when both presses qualify on the same edge

Behaviour:
- Reset is asynchronous and active-high on clk. While reset is high:
  - sync flops = released;
  - stable states = released;
  - counters = 0;
  - left = right = left_level = right_level = conflict = 0.
- Per channel, identical logic:
  - Sync: 2-flop synchronizer on inverted raw input, giving pressed-high sync2. Flops reset to 0.
  - Debounce, at each edge:
    - if sync2 == stable, then cnt <= 0;
    - else if cnt == DEBOUNCE_CYCLES-1, then stable <= sync2 and cnt <= 0;
    - else cnt <= cnt+1.
    - A single-cycle glitch (sync2 returning to stable before terminal count) restarts the counter from 0. Stable is not changed.
  - Press qualify: the qualify signal is high on the edge where stable goes 0->1. Release (1->0) produces no pulse.
- Latency: raw press first sampled at edge k, held steady. Then sync2 = 1 after edge k+1, and stable flips at edge k+1+DEBOUNCE_CYCLES. The pulse is registered on that same edge, so it is high for exactly one cycle following edge k+1+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+2 edges.
- Release latency is identical (DEBOUNCE_CYCLES+2 edges to left_level/right_level = 0). It produces no pulse.
- Arbitration, registered with the pulse:
  - only left qualifies: left = 1, right = 0;
  - only right qualifies: right = 1, left = 0;
  - both qualify on the same edge: left = right = 0 and conflict = 1 for one cycle. The controller keeps its prior selection.
  - A new press on one side while the other is held still pulses. Newest press wins; the held side never re-pulses.
- left and right are never both 1 in the same cycle.
- A held button produces exactly one pulse, no auto-repeat.
- left_level/right_level are stable registered outputs, independent of arbitration.
- Reset mid-debounce: the counter is cleared and no pulse is emitted. A button still held after reset deasserts counts from 0 and produces one pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Counter never exceeds DEBOUNCE_CYCLES-1. There is no wrap.

Decomposition:
- Package turn_sig_pkg:
  - constants PRESSED = 1'b1, RELEASED = 1'b0;
  - DEBOUNCE_CYCLES_DEFAULT = 16;
  - shared with the turn-signal controller and tail-light sequencer.
- Sub-module debounce_cell, parameterized by DEBOUNCE_CYCLES.
  - Contains synchronizer, counter, stable register and rise-qualify output.
  - Ports: clk, reset, raw_n, level, rise.
- Top instantiates two debounce_cells plus the registered arbitration and pulse logic (~30 lines).

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset asserted with left_sw_n=0 held: all outputs 0 throughout reset. After deassert, left=1 for exactly one cycle 6 edges later and left_level=1 from then on; right=0, conflict=0.
2. Left press bouncing (0,1,0,1 on successive edges) then steady 0 from edge 10: no pulse during bounce. Single left pulse after edge 15, then none while held. Release produces left_level=0 after 6 edges and no pulse.
3. left_sw_n and right_sw_n fall on the same edge, steady: conflict=1 for one cycle 6 edges later. left and right stay 0; both levels go to 1.
4. Right held steady, left pressed 20 cycles later: single left pulse 6 edges after left press. No right pulse repeats; right_level stays 1.
5. Left press held, reset pulsed for 1 cycle at edge 3 (mid-count): no pulse near edge 6. After reset, one left pulse 6 edges after the first post-reset edge.
6. Single-cycle right glitch (right_sw_n=0 for 1 edge only): right, right_level and conflict remain 0 for 20 cycles. Counter returns to 0.

Source files
------------

// File: rtl/turn_sig_pkg.sv
// Shared turn-signal constants used by the switch conditioner,
// the turn-signal controller and the tail-light sequencer.
package turn_sig_pkg;

    localparam logic PRESSED  = 1'b1;
    localparam logic RELEASED = 1'b0;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage : turn_sig_pkg

// File: rtl/turn_switch_conditioner_debounce_cell.sv
// One pushbutton channel: 2-flop synchronizer, debounce counter, stable state
// and a combinational rise qualifier that is high on the edge where stable goes 0->1.
module debounce_cell
    import turn_sig_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == TERM_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= RELEASED;
            r_sync2  <= RELEASED;
            r_stable <= RELEASED;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= ~raw_n;
            r_sync2 <= r_sync1;
            // Any cycle agreeing with stable restarts the qualification window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_term) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_stable;
    assign rise  = w_term && (r_sync2 == PRESSED) && (r_stable == RELEASED);

endmodule : debounce_cell

// File: rtl/turn_switch_conditioner.sv
// Front end for the turn-signal controller: debounces both active-low buttons
// and issues arbitrated one-cycle left/right request pulses plus a conflict pulse.
module turn_switch_conditioner
    import turn_sig_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw_n,
    input  logic right_sw_n,
    output logic left,
    output logic right,
    output logic left_level,
    output logic right_level,
    output logic conflict
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic w_left_rise;
    logic w_right_rise;
    logic r_left;
    logic r_right;
    logic r_conflict;

    debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .raw_n (left_sw_n),
        .level (left_level),
        .rise  (w_left_rise)
    );

    debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .raw_n (right_sw_n),
        .level (right_level),
        .rise  (w_right_rise)
    );

    // Simultaneous qualification is ambiguous, so neither side is requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_left     <= w_left_rise  & ~w_right_rise;
            r_right    <= w_right_rise & ~w_left_rise;
            r_conflict <= w_left_rise  &  w_right_rise;
        end
    end

    assign left     = r_left;
    assign right    = r_right;
    assign conflict = r_conflict;

endmodule : turn_switch_conditioner

// File: tb/tb_turn_switch_conditioner.sv
// Directed bench for turn_switch_conditioner with DEBOUNCE_CYCLES=4.
module tb_turn_switch_conditioner;

    logic clk;
    logic reset;
    logic left_sw_n;
    logic right_sw_n;
    logic left;
    logic right;
    logic left_level;
    logic right_level;
    logic conflict;

    int checks = 0;
    int errors = 0;

    // Observed vector ordering: {left, right, conflict, left_level, right_level}
    logic [4:0] obs;
    logic [4:0] exp_v;

    turn_switch_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .left_sw_n   (left_sw_n),
        .right_sw_n  (right_sw_n),
        .left        (left),
        .right       (right),
        .left_level  (left_level),
        .right_level (right_level),
        .conflict    (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        left_sw_n  = 1'b1;
        right_sw_n = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        left_sw_n  = 1'b0;
        right_sw_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = {left, right, conflict, left_level, right_level};
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs, 5'b00000);
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {n == 6, 1'b0, 1'b0, n >= 6, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_release edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
        left_sw_n = 1'b1;
    endtask

    task automatic test_bounce;
        do_reset();
        for (int n = 1; n <= 25; n++) begin
            if (n <= 4)      left_sw_n = (n % 2 == 0) ? 1'b1 : 1'b0;
            else if (n < 10) left_sw_n = 1'b1;
            else             left_sw_n = 1'b0;
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {n == 15, 1'b0, 1'b0, n >= 15, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce_press edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
        for (int n = 1; n <= 8; n++) begin
            left_sw_n = 1'b1;
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {1'b0, 1'b0, 1'b0, n < 6, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce_release edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_conflict;
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            left_sw_n  = 1'b0;
            right_sw_n = 1'b0;
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {1'b0, 1'b0, n == 6, n >= 6, n >= 6};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL conflict edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_newest_wins;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            right_sw_n = 1'b0;
            left_sw_n  = (n >= 21) ? 1'b0 : 1'b1;
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {n == 26, n == 6, 1'b0, n >= 26, n >= 6};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL newest_wins edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            left_sw_n = 1'b0;
            reset     = (n == 3);
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {n == 9, 1'b0, 1'b0, n >= 9, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_glitch;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            right_sw_n = (n == 1) ? 1'b0 : 1'b1;
            step();
            obs = {left, right, conflict, left_level, right_level};
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL glitch1 edge=%0d got=%b want=%b", n, obs, 5'b00000);
            end
        end
        checks++;
        if (dut.u_right.r_cnt !== '0) begin
            errors++;
            $display("FAIL glitch_cnt got=%0d want=0", dut.u_right.r_cnt);
        end
        // Three sampled edges low reaches the terminal count but not the flip.
        for (int n = 1; n <= 12; n++) begin
            right_sw_n = (n <= 3) ? 1'b0 : 1'b1;
            step();
            obs = {left, right, conflict, left_level, right_level};
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL glitch3 edge=%0d got=%b want=%b", n, obs, 5'b00000);
            end
        end
        for (int n = 1; n <= 14; n++) begin
            right_sw_n = (n <= 4) ? 1'b0 : 1'b1;
            step();
            obs   = {left, right, conflict, left_level, right_level};
            exp_v = {1'b0, n == 6, 1'b0, 1'b0, (n >= 6) && (n <= 9)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL press4 edge=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        left_sw_n  = 1'b1;
        right_sw_n = 1'b1;
        test_reset();
        test_bounce();
        test_conflict();
        test_newest_wins();
        test_reset_mid();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_turn_switch_conditioner
